// File: rtl/fifo_port_arbiter.sv
// Front-end controller for the single-port sync FIFO: round-robin write grant among
// NUM_WR producers, one consumer read path, write/read alternation under contention.
module fifo_port_arbiter #(
  parameter int NUM_WR = 4,
  parameter int DW     = 8,
  parameter int LVL_W  = 5
) (
  input  logic                 clk,
  input  logic                 reset,
  input  logic [NUM_WR-1:0]    wr_req,
  input  logic [NUM_WR*DW-1:0] wr_data,
  output logic [NUM_WR-1:0]    wr_gnt,
  input  logic                 rd_req,
  output logic                 rd_ack,
  output logic                 rd_valid,
  output logic [DW-1:0]        rd_data,
  output logic                 fifo_wr_en,
  output logic                 fifo_rd_en,
  output logic [DW-1:0]        fifo_din,
  input  logic                 fifo_full,
  input  logic                 fifo_empty,
  input  logic [DW-1:0]        fifo_dout,
  output logic [LVL_W-1:0]     level
);

  localparam int PTR_W = (NUM_WR > 1) ? $clog2(NUM_WR) : 1;

  typedef enum logic [1:0] {OP_IDLE, OP_WRITE, OP_READ} op_t;
  typedef enum logic {LAST_WRITE, LAST_READ} last_t;

  logic [PTR_W-1:0] rr_ptr, rr_ptr_nxt, gnt_idx;
  logic [PTR_W:0]   scan_idx;
  logic             found;
  logic             wr_ok, rd_ok;
  op_t              op;
  last_t            last_op, last_op_nxt;
  logic             rd_pend;

  assign wr_ok = (|wr_req) && !fifo_full;
  assign rd_ok = rd_req && !fifo_empty;

  // Round-robin search starting at rr_ptr, wrapping modulo NUM_WR.
  always_comb begin
    gnt_idx  = '0;
    found    = 1'b0;
    scan_idx = '0;
    for (int k = 0; k < NUM_WR; k++) begin
      scan_idx = {1'b0, rr_ptr} + (PTR_W+1)'(k);
      if (scan_idx >= (PTR_W+1)'(NUM_WR))
        scan_idx = scan_idx - (PTR_W+1)'(NUM_WR);
      if (!found && wr_req[scan_idx[PTR_W-1:0]]) begin
        found   = 1'b1;
        gnt_idx = scan_idx[PTR_W-1:0];
      end
    end
  end

  // Operation select and next-state; reset forces IDLE so strobes stay low.
  always_comb begin
    op          = OP_IDLE;
    last_op_nxt = last_op;
    rr_ptr_nxt  = rr_ptr;
    if (!reset) begin
      if (wr_ok && rd_ok)
        op = (last_op == LAST_READ) ? OP_WRITE : OP_READ;
      else if (wr_ok)
        op = OP_WRITE;
      else if (rd_ok)
        op = OP_READ;
    end
    case (op)
      OP_WRITE: begin
        last_op_nxt = LAST_WRITE;
        rr_ptr_nxt  = (gnt_idx == PTR_W'(NUM_WR-1)) ? '0 : gnt_idx + 1'b1;
      end
      OP_READ:  last_op_nxt = LAST_READ;
      default:  ;
    endcase
  end

  always_comb begin
    wr_gnt     = '0;
    fifo_din   = '0;
    fifo_wr_en = 1'b0;
    fifo_rd_en = 1'b0;
    rd_ack     = 1'b0;
    if (op == OP_WRITE) begin
      wr_gnt[gnt_idx] = 1'b1;
      fifo_din        = wr_data[gnt_idx*DW +: DW];
      fifo_wr_en      = 1'b1;
    end else if (op == OP_READ) begin
      fifo_rd_en = 1'b1;
      rd_ack     = 1'b1;
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      rr_ptr  <= '0;
      last_op <= LAST_READ;
      level   <= '0;
    end else begin
      rr_ptr  <= rr_ptr_nxt;
      last_op <= last_op_nxt;
      case (op)
        OP_WRITE: level <= level + 1'b1;
        OP_READ:  level <= level - 1'b1;
        default:  ;
      endcase
    end
  end

  // Read return: rd_pend marks the cycle the FIFO presents data; capture it one edge later.
  always_ff @(posedge clk) begin
    if (reset) begin
      rd_pend  <= 1'b0;
      rd_valid <= 1'b0;
      rd_data  <= '0;
    end else begin
      rd_pend  <= (op == OP_READ);
      rd_valid <= rd_pend;
      if (rd_pend)
        rd_data <= fifo_dout;
    end
  end

  a_level_no_underflow: assert property (@(posedge clk) disable iff (reset)
    (op == OP_READ) |-> (level != '0));
  a_level_no_overflow: assert property (@(posedge clk) disable iff (reset)
    (op == OP_WRITE) |-> (level != '1));

endmodule

// File: doc/fifo_port_arbiter.md
Name: fifo_port_arbiter

Overview:
- Front-end controller for the team's single-port-operation sync FIFO. That FIFO performs one write or one read per cycle and has 8-bit data and full/empty flags.
- Shares the FIFO write side among NUM_WR producers using round-robin arbitration.
- Serves one consumer's read requests and alternates write and read when both contend.
- Sits between the producer/consumer logic and the FIFO instance, and is the only agent driving the FIFO controls.

Parameters:
- NUM_WR, 4, number of write requesters (2..8).
- DW, 8, data width; matches the FIFO data width.
- LVL_W, 5, width of the shadow occupancy counter; must hold FIFO depth.

Ports:
- clk  input  1  rising-edge clock.
- reset  input  1  synchronous, active-high reset.
- wr_req  input  NUM_WR  per-producer write request, level-held until granted.
- wr_data  input  NUM_WR*DW  producer data; slice i is bits [i*DW +: DW].
- wr_gnt  output  NUM_WR  one-hot, combinational; bit i high means slice i is written this cycle.
- rd_req  input  1  consumer read request, level-held.
- rd_ack  output  1  combinational; a read is issued to the FIFO this cycle.
- rd_valid  output  1  registered; rd_data is valid this cycle.
- rd_data  output  DW  registered read data.
- fifo_wr_en  output  1  FIFO write strobe.
- fifo_rd_en  output  1  FIFO read strobe; never high together with fifo_wr_en.
- fifo_din  output  DW  data to the FIFO; equals the granted slice, else 0.
- fifo_full  input  1  FIFO full flag.
- fifo_empty  input  1  FIFO empty flag.
- fifo_dout  input  DW  FIFO registered read data, valid the cycle after the read.
- level  output  LVL_W  shadow occupancy: writes issued minus reads issued.

Behaviour:
- Reset is synchronous and active-high. On reset:
  - rr_ptr=0.
  - last_op=READ, so the first contended cycle chooses WRITE.
  - rd_valid=0, rd_data=0, level=0, and the internal rd_pend flag=0.
  - Combinational outputs are don't-care in the reset cycle, but fifo_wr_en and fifo_rd_en must be 0 whenever reset=1.
- Eligibility, evaluated every cycle:
  - wr_ok = |wr_req & !fifo_full.
  - rd_ok = rd_req & !fifo_empty.
- Operation select:
  - wr_ok only: WRITE.
  - rd_ok only: READ.
  - Both: the opposite of last_op.
  - Neither: IDLE, with both strobes 0.
  - last_op updates only on WRITE or READ cycles; it holds on IDLE.
- Round robin for WRITE:
  - Grant the first asserted wr_req at index rr_ptr, rr_ptr+1, ..., wrapping modulo NUM_WR.
  - Next cycle, rr_ptr = granted index + 1, wrapping NUM_WR-1 -> 0.
  - rr_ptr holds on READ and IDLE cycles.
- WRITE cycle outputs: wr_gnt one-hot, fifo_wr_en=1, fifo_din = the granted slice.
- READ cycle outputs: rd_ack=1, fifo_rd_en=1, and rd_pend is set for the next cycle.
- Read return (latency 1):
  - In the cycle after fifo_rd_en, rd_pend=1. rd_valid asserts on the following clock edge, with rd_data sampled from fifo_dout.
  - Net: rd_ack in cycle N, the FIFO presents data in cycle N+1, and rd_valid/rd_data are seen in cycle N+2.
  - rd_valid is a single-cycle pulse per read. Back-to-back reads give back-to-back rd_valid.
  - rd_data holds its value when rd_valid=0.
- level arithmetic:
  - +1 on WRITE, -1 on READ, hold otherwise. The two never occur in the same cycle.
  - No wrap in legal use, because the flags gate strobes.
  - Assertion (simulation): level never underflows, and it equals the FIFO count.
- Boundaries:
  - fifo_full=1: no wr_gnt, and producers stall holding their data.
  - fifo_empty=1: no rd_ack.
  - When full and rd_req are both present, READ is chosen irrespective of last_op, since wr_ok=0.
  - A requester that drops wr_req before being granted loses its slot with no side effect.
  - Reset asserted mid-read (rd_pend=1) clears rd_pend, so no rd_valid follows.

Test Plan:
- Reset, then all four wr_req held with data 0x10,0x11,0x12,0x13, FIFO not full -> wr_gnt sequence 0001,0010,0100,1000,0001; level increments 1..5.
- Preload 3 entries 0xA1,0xA2,0xA3, rd_req held, no wr_req -> rd_ack in cycles 0,1,2; rd_valid in cycles 2,3,4 with rd_data A1,A2,A3; level 3->0; no rd_ack once fifo_empty=1.
- wr_req[2]=1 and rd_req=1 held with FIFO nonempty and nonfull, after reset -> ops alternate WRITE,READ,WRITE,READ; strobes never coincide.
- Fill to fifo_full=1 with wr_req[0] and rd_req held -> wr_gnt=0, READ chosen every cycle until full deasserts, then alternation resumes starting with WRITE.
- Only wr_req[3] and wr_req[1] asserted, rr_ptr=2 -> grant idx3, then idx1, then idx3.
- rd_ack issued, reset asserted the next cycle -> rd_valid stays 0; level=0 and rr_ptr=0 after reset.
